// File: rtl/dmem_arbiter_if.sv
// Two-port request/response bus plus the dmem-side signals of the data-memory arbiter.
// The arbiter uses the slave view; the requesters and memory model use the master view.
interface dmem_arbiter_if #(
    parameter int N = 32
);
    logic         p0_req;
    logic         p0_we;
    logic [N-1:0] p0_addr;
    logic [N-1:0] p0_wdata;
    logic         p0_done;
    logic [N-1:0] p0_rdata;
    logic         p0_err;

    logic         p1_req;
    logic         p1_we;
    logic [N-1:0] p1_addr;
    logic [N-1:0] p1_wdata;
    logic         p1_done;
    logic [N-1:0] p1_rdata;
    logic         p1_err;

    logic [N-1:0] mem_addr;
    logic [N-1:0] mem_wdata;
    logic         mem_we;
    logic [N-1:0] mem_rdata;
    logic         busy;

    modport slave (
        input  p0_req, p0_we, p0_addr, p0_wdata,
        output p0_done, p0_rdata, p0_err,
        input  p1_req, p1_we, p1_addr, p1_wdata,
        output p1_done, p1_rdata, p1_err,
        output mem_addr, mem_wdata, mem_we,
        input  mem_rdata,
        output busy
    );

    modport master (
        output p0_req, p0_we, p0_addr, p0_wdata,
        input  p0_done, p0_rdata, p0_err,
        output p1_req, p1_we, p1_addr, p1_wdata,
        input  p1_done, p1_rdata, p1_err,
        input  mem_addr, mem_wdata, mem_we,
        output mem_rdata,
        input  busy
    );
endinterface

// File: rtl/dmem_arbiter.sv
// Round-robin two-port arbiter in front of dmem: one word access per IDLE->ACCESS->RESP (3 cycles).
// Requesters hold req until their done pulse; a losing request simply waits for the next IDLE.
module dmem_arbiter #(
    parameter int N         = 32,
    parameter int MEM_BYTES = 1024
) (
    input  logic            clk,
    input  logic            rst_,
    dmem_arbiter_if.slave   bus
);
    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_ACCESS = 2'd1,
        S_RESP   = 2'd2
    } state_t;

    localparam logic [N-1:0] MEM_LIM = N'(MEM_BYTES);

    state_t         state_q, state_d;
    logic           owner_q, owner_d;
    logic           last_owner_q, last_owner_d;
    logic           lat_we_q, lat_we_d;
    logic           lat_err_q, lat_err_d;
    logic [N-1:2]   lat_addr_q, lat_addr_d;
    logic [N-1:0]   lat_wdata_q, lat_wdata_d;
    logic           p0_done_q, p0_done_d;
    logic           p1_done_q, p1_done_d;
    logic [N-1:0]   p0_rdata_q, p0_rdata_d;
    logic [N-1:0]   p1_rdata_q, p1_rdata_d;
    logic           p0_err_q, p0_err_d;
    logic           p1_err_q, p1_err_d;

    logic           pick1;
    logic [N-1:0]   sel_addr;
    logic [N-1:0]   rd_val;

    always_comb begin
        state_d      = state_q;
        owner_d      = owner_q;
        last_owner_d = last_owner_q;
        lat_we_d     = lat_we_q;
        lat_err_d    = lat_err_q;
        lat_addr_d   = lat_addr_q;
        lat_wdata_d  = lat_wdata_q;
        p0_done_d    = 1'b0;
        p1_done_d    = 1'b0;
        p0_rdata_d   = '0;
        p1_rdata_d   = '0;
        p0_err_d     = 1'b0;
        p1_err_d     = 1'b0;
        // Port 1 wins when alone, or when both ask and port 0 was served last.
        pick1        = bus.p1_req & (~bus.p0_req | ~last_owner_q);
        sel_addr     = pick1 ? bus.p1_addr : bus.p0_addr;
        rd_val       = (lat_we_q | lat_err_q) ? '0 : bus.mem_rdata;

        case (state_q)
            S_IDLE: begin
                if (bus.p0_req | bus.p1_req) begin
                    owner_d     = pick1;
                    lat_we_d    = pick1 ? bus.p1_we : bus.p0_we;
                    lat_wdata_d = pick1 ? bus.p1_wdata : bus.p0_wdata;
                    lat_addr_d  = sel_addr[N-1:2];
                    lat_err_d   = (sel_addr >= MEM_LIM);
                    state_d     = S_ACCESS;
                end
            end
            S_ACCESS: begin
                if (owner_q) begin
                    p1_done_d  = 1'b1;
                    p1_rdata_d = rd_val;
                    p1_err_d   = lat_err_q;
                end else begin
                    p0_done_d  = 1'b1;
                    p0_rdata_d = rd_val;
                    p0_err_d   = lat_err_q;
                end
                state_d = S_RESP;
            end
            S_RESP: begin
                last_owner_d = owner_q;
                state_d      = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_) begin
        if (!rst_) begin
            state_q      <= S_IDLE;
            owner_q      <= 1'b0;
            last_owner_q <= 1'b1;
            lat_we_q     <= 1'b0;
            lat_err_q    <= 1'b0;
            lat_addr_q   <= '0;
            lat_wdata_q  <= '0;
            p0_done_q    <= 1'b0;
            p1_done_q    <= 1'b0;
            p0_rdata_q   <= '0;
            p1_rdata_q   <= '0;
            p0_err_q     <= 1'b0;
            p1_err_q     <= 1'b0;
        end else begin
            state_q      <= state_d;
            owner_q      <= owner_d;
            last_owner_q <= last_owner_d;
            lat_we_q     <= lat_we_d;
            lat_err_q    <= lat_err_d;
            lat_addr_q   <= lat_addr_d;
            lat_wdata_q  <= lat_wdata_d;
            p0_done_q    <= p0_done_d;
            p1_done_q    <= p1_done_d;
            p0_rdata_q   <= p0_rdata_d;
            p1_rdata_q   <= p1_rdata_d;
            p0_err_q     <= p0_err_d;
            p1_err_q     <= p1_err_d;
        end
    end

    // mem_we is combinational so it falls together with an asynchronous reset.
    assign bus.mem_we    = (state_q == S_ACCESS) & lat_we_q & ~lat_err_q;
    assign bus.mem_addr  = {lat_addr_q, 2'b00};
    assign bus.mem_wdata = lat_wdata_q;
    assign bus.busy      = (state_q != S_IDLE);
    assign bus.p0_done   = p0_done_q;
    assign bus.p0_rdata  = p0_rdata_q;
    assign bus.p0_err    = p0_err_q;
    assign bus.p1_done   = p1_done_q;
    assign bus.p1_rdata  = p1_rdata_q;
    assign bus.p1_err    = p1_err_q;
endmodule
